// File: rtl/gpr_wb_regfile.sv
// gpr_wb_regfile: writeback-stage GPR file for the single-issue RV32 core.
//
// Holds the architectural registers and a per-register pending-write scoreboard
// of saturating counters. Issue increments the counter of its destination and
// writeback decrements it, so decode can stall on RAW hazards (rsN_busy) and
// issue can stall when a counter is saturated (iss_ready).
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   iss_valid/ready      issue handshake; iss_w_en/iss_rd describe the destination
//   wb_valid/ready       writeback handshake; wb_w_en/wb_rd/wb_data carry the result
//   rs1_addr, rs2_addr   combinational read indices
//   src1, src2           read data (x0 and out-of-range indices read 0)
//   rs1_busy, rs2_busy   index has outstanding writes
//   sb_err               sticky: writeback underflow or out-of-range index
//
// Build option: define GPR_BYPASS_EN to forward the writeback beat to the read
// ports in the same cycle and drop busy when that beat retires the last write.

module gpr_wb_regfile #(
    parameter int unsigned ISA_WIDTH  = 32,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned SB_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic                  iss_w_en,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic                  wb_w_en,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [ISA_WIDTH-1:0]  wb_data,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [ISA_WIDTH-1:0]  src1,
    output logic [ISA_WIDTH-1:0]  src2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  sb_err
);

    localparam logic [SB_WIDTH-1:0] CntMax    = '1;
    localparam logic [SB_WIDTH-1:0] CntOne    = SB_WIDTH'(1);
    localparam int unsigned         AddrSpan  = 1 << ADDR_WIDTH;

    logic [ISA_WIDTH-1:0] regs_q [REG_NUM];
    logic [ISA_WIDTH-1:0] regs_d [REG_NUM];
    logic [SB_WIDTH-1:0]  cnt_q  [REG_NUM];
    logic [SB_WIDTH-1:0]  cnt_d  [REG_NUM];
    logic                 sb_err_q, sb_err_d;

    logic wb_in_range, iss_in_range, rs1_in_range, rs2_in_range;

    // When the index space is fully populated no index can be out of range.
    if (REG_NUM >= AddrSpan) begin : g_full_range
        assign wb_in_range  = 1'b1;
        assign iss_in_range = 1'b1;
        assign rs1_in_range = 1'b1;
        assign rs2_in_range = 1'b1;
    end else begin : g_part_range
        assign wb_in_range  = (32'(wb_rd) < REG_NUM);
        assign iss_in_range = (32'(iss_rd) < REG_NUM);
        assign rs1_in_range = (32'(rs1_addr) < REG_NUM);
        assign rs2_in_range = (32'(rs2_addr) < REG_NUM);
    end

    logic                wb_fire, wb_write;
    logic                iss_fire, iss_count;
    logic [SB_WIDTH-1:0] wb_cnt, iss_cnt;
    logic                same_rd;
    logic                underflow;

    assign wb_ready = ~rst;
    assign wb_fire  = wb_valid & wb_ready & wb_w_en & (wb_rd != '0);
    assign wb_write = wb_fire & wb_in_range;

    assign wb_cnt  = wb_in_range  ? cnt_q[wb_rd]  : '0;
    assign iss_cnt = iss_in_range ? cnt_q[iss_rd] : '0;
    assign same_rd = (wb_rd == iss_rd);

    // A retiring write to the same register frees a slot in the same cycle.
    assign iss_ready = ~rst & ~(iss_w_en & (iss_rd != '0) & (iss_cnt == CntMax) &
                                ~(wb_fire & same_rd));
    assign iss_fire  = iss_valid & iss_ready & iss_w_en & (iss_rd != '0);
    assign iss_count = iss_fire & iss_in_range;

    // Issue and retire on the same register cancel, so that pair never underflows.
    assign underflow = wb_write & (wb_cnt == '0) & ~(iss_count & same_rd);

    always_comb begin
        for (int i = 0; i < int'(REG_NUM); i++) begin
            regs_d[i] = regs_q[i];
            cnt_d[i]  = cnt_q[i];
        end
        if (wb_write) begin
            regs_d[wb_rd] = wb_data;
        end
        if (!(iss_count && wb_write && same_rd)) begin
            if (iss_count) begin
                cnt_d[iss_rd] = iss_cnt + CntOne;
            end
            if (wb_write && (wb_cnt != '0)) begin
                cnt_d[wb_rd] = wb_cnt - CntOne;
            end
        end
        sb_err_d = sb_err_q | underflow | (wb_fire & ~wb_in_range) |
                   (iss_fire & ~iss_in_range);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

    always_comb begin
        src1     = '0;
        rs1_busy = 1'b0;
        if ((rs1_addr != '0) && rs1_in_range) begin
            src1     = regs_q[rs1_addr];
            rs1_busy = (cnt_q[rs1_addr] != '0);
`ifdef GPR_BYPASS_EN
            if (wb_write && (wb_rd == rs1_addr)) begin
                src1 = wb_data;
                if (cnt_q[rs1_addr] == CntOne) begin
                    rs1_busy = 1'b0;
                end
            end
`endif
        end
    end

    always_comb begin
        src2     = '0;
        rs2_busy = 1'b0;
        if ((rs2_addr != '0) && rs2_in_range) begin
            src2     = regs_q[rs2_addr];
            rs2_busy = (cnt_q[rs2_addr] != '0);
`ifdef GPR_BYPASS_EN
            if (wb_write && (wb_rd == rs2_addr)) begin
                src2 = wb_data;
                if (cnt_q[rs2_addr] == CntOne) begin
                    rs2_busy = 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_gpr_wb_regfile.sv
// Self-checking bench for gpr_wb_regfile: reset sequence, a directed vector table
// and a randomized run against a reference model.

module tb_gpr_wb_regfile;

`ifdef GPR_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_ready, iss_w_en;
    logic [4:0]  iss_rd;
    logic        wb_valid, wb_ready, wb_w_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] src1, src2;
    logic        rs1_busy, rs2_busy, sb_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gpr_wb_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_w_en  (iss_w_en),
        .iss_rd    (iss_rd),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_w_en   (wb_w_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .src1      (src1),
        .src2      (src2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .sb_err    (sb_err)
    );

    typedef struct {
        logic        iv, iw;
        logic [4:0]  ird;
        logic        wv, ww;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic [4:0]  r1, r2;
        logic [31:0] e_s1, e_s2;
        logic        e_b1, e_b2, e_rdy, e_err;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic iv, logic iw, logic [4:0] ird, logic wv, logic ww,
                                logic [4:0] wrd, logic [31:0] wd, logic [4:0] r1,
                                logic [4:0] r2, logic [31:0] e_s1, logic [31:0] e_s2,
                                logic e_b1, logic e_b2, logic e_rdy, logic e_err);
        vec_t v;
        v.iv = iv; v.iw = iw; v.ird = ird; v.wv = wv; v.ww = ww; v.wrd = wrd; v.wd = wd;
        v.r1 = r1; v.r2 = r2; v.e_s1 = e_s1; v.e_s2 = e_s2; v.e_b1 = e_b1; v.e_b2 = e_b2;
        v.e_rdy = e_rdy; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic iw, input logic [4:0] ird,
                         input logic wv, input logic ww, input logic [4:0] wrd,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        iss_valid = iv; iss_w_en = iw; iss_rd = ird;
        wb_valid = wv; wb_w_en = ww; wb_rd = wrd; wb_data = wd;
        rs1_addr = r1; rs2_addr = r2;
    endtask

    // Reference model state.
    logic [31:0] m_reg[32];
    int          m_cnt[32];
    bit          m_err;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endtask

    initial begin
        logic [31:0] e_s1, e_s2;
        logic        e_b1, e_b2, e_rdy, wbf, issf;
        logic [4:0]  r, ird, wrd;

        tbl[0]  = mk(1, 1, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 1, 1, 3, 32'hDEADBEEF, 3, 0,
                     Byp ? 32'hDEADBEEF : 32'h0, 0, !Byp, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0);
        tbl[4]  = mk(1, 1, 7, 0, 0, 0, 0, 3, 7, 32'hDEADBEEF, 0, 0, 0, 1, 0);
        tbl[5]  = mk(1, 1, 7, 0, 0, 0, 0, 3, 7, 32'hDEADBEEF, 0, 0, 1, 1, 0);
        tbl[6]  = mk(1, 1, 7, 0, 0, 0, 0, 3, 7, 32'hDEADBEEF, 0, 0, 1, 1, 0);
        tbl[7]  = mk(1, 1, 7, 0, 0, 0, 0, 3, 7, 32'hDEADBEEF, 0, 0, 1, 0, 0);
        tbl[8]  = mk(1, 1, 7, 1, 1, 7, 32'h77, 3, 7, 32'hDEADBEEF,
                     Byp ? 32'h77 : 32'h0, 0, 1, 1, 0);
        tbl[9]  = mk(0, 1, 7, 0, 0, 0, 0, 3, 7, 32'hDEADBEEF, 32'h77, 0, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 1, 0, 32'hFFFFFFFF, 0, 7, 0, 32'h77, 0, 1, 1, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 0, 0, 0, 7, 0, 32'h77, 0, 1, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'h77, 0, 1, 1, 0);
        tbl[13] = mk(0, 0, 0, 1, 1, 9, 32'h99, 0, 9, 0, Byp ? 32'h99 : 32'h0, 0, 0, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h99, 0, 0, 1, 1);
        tbl[15] = mk(0, 0, 0, 1, 1, 7, 32'h71, 0, 7, 0, Byp ? 32'h71 : 32'h77, 0, 1, 1, 1);
        tbl[16] = mk(0, 0, 0, 1, 1, 7, 32'h72, 0, 7, 0, Byp ? 32'h72 : 32'h71, 0, 1, 1, 1);
        tbl[17] = mk(0, 0, 0, 1, 1, 7, 32'h73, 0, 7, 0, Byp ? 32'h73 : 32'h72, 0, !Byp,
                     1, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'h73, 0, 0, 1, 1);
        tbl[19] = mk(1, 1, 4, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 1, 1);
        tbl[20] = mk(0, 0, 0, 1, 1, 4, 32'h55, 0, 4, 0, Byp ? 32'h55 : 32'h0, 0, !Byp,
                     1, 1);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 32'h55, 0, 0, 1, 1);

        // Initial reset.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of operation after x5 has been written.
        drive(0, 0, 0, 1, 1, 5, 32'h1234, 5, 0);
        @(negedge clk);
        drive(1, 1, 5, 0, 0, 0, 0, 5, 0);
        #2;
        chk("pre_rst src1", src1, 32'h1234);
        chk("pre_rst sb_err", 32'(sb_err), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst src1", src1, 32'h0);
        chk("rst rs1_busy", 32'(rs1_busy), 32'd0);
        chk("rst sb_err", 32'(sb_err), 32'd0);
        chk("rst wb_ready", 32'(wb_ready), 32'd0);
        chk("rst iss_ready", 32'(iss_ready), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 5, 0);
        rst = 1'b0;
        #2;
        chk("post_rst src1", src1, 32'h0);
        chk("post_rst rs1_busy", 32'(rs1_busy), 32'd0);
        chk("post_rst wb_ready", 32'(wb_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].iw, tbl[i].ird, tbl[i].wv, tbl[i].ww, tbl[i].wrd,
                  tbl[i].wd, tbl[i].r1, tbl[i].r2);
            #2;
            chk($sformatf("row%0d src1", i), src1, tbl[i].e_s1);
            chk($sformatf("row%0d src2", i), src2, tbl[i].e_s2);
            chk($sformatf("row%0d rs1_busy", i), 32'(rs1_busy), 32'(tbl[i].e_b1));
            chk($sformatf("row%0d rs2_busy", i), 32'(rs2_busy), 32'(tbl[i].e_b2));
            chk($sformatf("row%0d iss_ready", i), 32'(iss_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("row%0d sb_err", i), 32'(sb_err), 32'(tbl[i].e_err));
            chk($sformatf("row%0d wb_ready", i), 32'(wb_ready), 32'd1);
        end

        // Randomized run against the reference model.
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            ird = 5'($urandom_range(0, 7));
            wrd = 5'($urandom_range(0, 7));
            // Mostly retire registers that actually have writes pending.
            if ($urandom_range(0, 9) != 0) begin
                r = 5'($urandom_range(1, 7));
                for (int k = 0; k < 7; k++) begin
                    if (m_cnt[((int'(r) - 1 + k) % 7) + 1] > 0) begin
                        wrd = 5'(((int'(r) - 1 + k) % 7) + 1);
                        break;
                    end
                end
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), ird,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) != 0), wrd,
                  $urandom, 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));

            wbf   = wb_valid && wb_w_en && (wb_rd != 0);
            e_rdy = !(iss_w_en && (iss_rd != 0) && (m_cnt[iss_rd] == 3) &&
                      !(wbf && (wb_rd == iss_rd)));
            issf  = iss_valid && e_rdy && iss_w_en && (iss_rd != 0);
            e_s1  = (rs1_addr == 0) ? 32'h0 :
                    (Byp && wbf && (wb_rd == rs1_addr)) ? wb_data : m_reg[rs1_addr];
            e_s2  = (rs2_addr == 0) ? 32'h0 :
                    (Byp && wbf && (wb_rd == rs2_addr)) ? wb_data : m_reg[rs2_addr];
            e_b1  = (rs1_addr != 0) && (m_cnt[rs1_addr] != 0) &&
                    !(Byp && wbf && (wb_rd == rs1_addr) && (m_cnt[rs1_addr] == 1));
            e_b2  = (rs2_addr != 0) && (m_cnt[rs2_addr] != 0) &&
                    !(Byp && wbf && (wb_rd == rs2_addr) && (m_cnt[rs2_addr] == 1));
            #2;
            chk($sformatf("rnd%0d src1", c), src1, e_s1);
            chk($sformatf("rnd%0d src2", c), src2, e_s2);
            chk($sformatf("rnd%0d rs1_busy", c), 32'(rs1_busy), 32'(e_b1));
            chk($sformatf("rnd%0d rs2_busy", c), 32'(rs2_busy), 32'(e_b2));
            chk($sformatf("rnd%0d iss_ready", c), 32'(iss_ready), 32'(e_rdy));
            chk($sformatf("rnd%0d sb_err", c), 32'(sb_err), 32'(m_err));

            // Architectural effect of this cycle.
            if (wbf) m_reg[wb_rd] = wb_data;
            if (!(issf && wbf && (iss_rd == wb_rd))) begin
                if (issf) m_cnt[iss_rd]++;
                if (wbf) begin
                    if (m_cnt[wb_rd] == 0) m_err = 1'b1;
                    else m_cnt[wb_rd]--;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
